// File: rtl/alu_operand_stack_pkg.sv
// Shared types for the ALU operand stack: sequencer states, completion codes
// and the pop/push count clamp.
package alu_operand_stack_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RES  = 3'd2,
    WAIT_NEXT = 3'd3,
    FIN       = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_UNDER = 2'd1,
    ERR_OVER  = 2'd2,
    ERR_PROTO = 2'd3
  } err_e;

  // Pop/push requests of 3 behave as 2.
  function automatic logic [1:0] clamp_cnt(input logic [1:0] n);
    return (n == 2'd3) ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/alu_operand_stack_stack_regfile.sv
// Stack storage: DEPTH x DATA_W registers, two combinational read ports and
// two write ports; contents are deliberately not reset.
module stack_regfile
  import alu_operand_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic [AW-1:0]     rd_addr1,
  input  logic [AW-1:0]     rd_addr2,
  output logic [DATA_W-1:0] rd_data1_c,
  output logic [DATA_W-1:0] rd_data2_c,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [AW-1:0]     wa2,
  input  logic [DATA_W-1:0] wd2
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign rd_data1_c = mem_q[rd_addr1];
  assign rd_data2_c = mem_q[rd_addr2];

  always_comb begin
    mem_d = mem_q;
    if (we1) mem_d[wa1] = wd1;
    if (we2) mem_d[wa2] = wd2;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_operand_stack.sv
// Data-stack sequencer around the ALU: pops operands, pulses the ALU enable,
// pushes results back and reports completion; also takes immediate pushes.
module alu_operand_stack
  import alu_operand_stack_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [1:0]        n_pop,
  input  logic [1:0]        n_push,
  input  logic              ext_push,
  input  logic [DATA_W-1:0] ext_data,
  output logic              alu_enable,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out1,
  input  logic [DATA_W-1:0] alu_out2,
  input  logic              alu_push_result,
  input  logic              alu_next,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [AW:0]       count,
  output logic [DATA_W-1:0] top
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = AW + 2;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        n_push_q, n_push_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              alu_enable_q, alu_enable_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  err_e              err_q, err_d;

  logic [DATA_W-1:0] rd1_c, rd2_c, wd1_c;
  logic              we1_c, we2_c;
  logic [1:0]        np_c, nu_c;
  logic [EW-1:0]     depth_after_c;
  logic [TW-1:0]     timer_inc_c;
  logic              timed_out_c;

  stack_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk        (clk),
    .rd_addr1   (AW'(count_q - CW'(1))),
    .rd_addr2   (AW'(count_q - CW'(2))),
    .rd_data1_c (rd1_c),
    .rd_data2_c (rd2_c),
    .we1        (we1_c),
    .wa1        (AW'(count_q)),
    .wd1        (wd1_c),
    .we2        (we2_c),
    .wa2        (AW'(count_q + CW'(1))),
    .wd2        (alu_out2)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      n_push_q     <= '0;
      timer_q      <= '0;
      alu_enable_q <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      n_push_q     <= n_push_d;
      timer_q      <= timer_d;
      alu_enable_q <= alu_enable_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    n_push_d      = n_push_q;
    timer_d       = timer_q;
    alu_in1_d     = alu_in1_q;
    alu_in2_d     = alu_in2_q;
    err_d         = err_q;
    we1_c         = 1'b0;
    we2_c         = 1'b0;
    wd1_c         = alu_out1;
    np_c          = clamp_cnt(n_pop);
    nu_c          = clamp_cnt(n_push);
    depth_after_c = EW'(count_q) - EW'(np_c) + EW'(nu_c);
    timer_inc_c   = TW'(timer_q + TW'(1));
    timed_out_c   = (timer_inc_c == TW'(TIMEOUT));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count_q < CW'(np_c)) begin
            state_d = FIN;
            err_d   = ERR_UNDER;
          end else if (depth_after_c > EW'(DEPTH)) begin
            state_d = FIN;
            err_d   = ERR_OVER;
          end else begin
            alu_in1_d = (np_c != 2'd0) ? rd1_c : '0;
            alu_in2_d = (np_c == 2'd2) ? rd2_c : '0;
            count_d   = count_q - CW'(np_c);
            n_push_d  = nu_c;
            state_d   = ISSUE;
          end
        end else if (ext_push) begin
          if (count_q < CW'(DEPTH)) begin
            we1_c   = 1'b1;
            wd1_c   = ext_data;
            count_d = count_q + CW'(1);
          end else begin
            state_d = FIN;
            err_d   = ERR_OVER;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_RES;
        timer_d = '0;
      end
      WAIT_RES: begin
        // A push alongside alu_next still commits the results before finishing.
        if (alu_push_result) begin
          we1_c   = (n_push_q != 2'd0);
          we2_c   = (n_push_q == 2'd2);
          count_d = count_q + CW'(n_push_q);
          timer_d = '0;
          if (alu_next) begin
            state_d = FIN;
            err_d   = ERR_NONE;
          end else begin
            state_d = WAIT_NEXT;
          end
        end else if (alu_next || timed_out_c) begin
          state_d = FIN;
          err_d   = ERR_PROTO;
        end else begin
          timer_d = timer_inc_c;
        end
      end
      WAIT_NEXT: begin
        if (alu_next) begin
          state_d = FIN;
          err_d   = ERR_NONE;
        end else if (timed_out_c) begin
          state_d = FIN;
          err_d   = ERR_PROTO;
        end else begin
          timer_d = timer_inc_c;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    alu_enable_d = (state_d == ISSUE);
    done_d       = (state_d == FIN);
    busy_d       = (state_d != IDLE);
  end

  assign alu_enable = alu_enable_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign count      = count_q;
  assign top        = (count_q == '0) ? '0 : rd1_c;

endmodule

// File: tb/tb_alu_operand_stack.sv
// Scoreboard bench for alu_operand_stack: a queue-based stack model predicts
// operands and completion records; a monitor compares whenever the DUT reports.
module tb_alu_operand_stack;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 15;

  logic        clk, nrst, start, ext_push, alu_push_result, alu_next;
  logic [1:0]  n_pop, n_push, err;
  logic [31:0] ext_data, alu_in1, alu_in2, alu_out1, alu_out2, top;
  logic        alu_enable, busy, done;
  logic [4:0]  count;

  alu_operand_stack #(.DEPTH(16), .AW(4), .TIMEOUT(15)) dut (
    .clk(clk), .nrst(nrst), .start(start), .n_pop(n_pop), .n_push(n_push),
    .ext_push(ext_push), .ext_data(ext_data), .alu_enable(alu_enable),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out1(alu_out1), .alu_out2(alu_out2),
    .alu_push_result(alu_push_result), .alu_next(alu_next), .busy(busy),
    .done(done), .err(err), .count(count), .top(top)
  );

  typedef struct { logic [1:0] err; int cnt; logic [31:0] top; } done_exp_t;
  typedef struct { logic [31:0] in1; logic [31:0] in2; } op_exp_t;

  done_exp_t   done_q[$];
  op_exp_t     op_q[$];
  logic [31:0] stk[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  done_exp_t   mon_d;
  op_exp_t     mon_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mtop();
    return (stk.size() > 0) ? stk[$] : 32'd0;
  endfunction

  // Monitor: every DUT report must match the oldest prediction.
  always @(negedge clk) begin
    if (nrst) begin
      if (alu_enable) begin
        if (op_q.size() == 0) chk("unexpected_alu_enable", 1, 0);
        else begin
          mon_o = op_q.pop_front();
          chk("alu_in1", alu_in1, mon_o.in1);
          chk("alu_in2", alu_in2, mon_o.in2);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mon_d = done_q.pop_front();
          chk("err", 32'(err), 32'(mon_d.err));
          chk("count_at_done", 32'(count), mon_d.cnt);
          chk("top_at_done", top, mon_d.top);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_ext(input logic [31:0] v);
    done_exp_t d;
    int c;
    bit full;
    full = (stk.size() >= DEPTH);
    if (full) begin
      d.err = 2'd2; d.cnt = DEPTH; d.top = mtop();
      done_q.push_back(d);
    end else stk.push_back(v);
    step();
    ext_push = 1'b1; ext_data = v;
    step();
    ext_push = 1'b0;
    if (full) begin
      wait_done(c);
      chk("ext_full_latency", c, 1);
    end else begin
      @(negedge clk);
      chk("ext_count", 32'(count), stk.size());
      chk("ext_top", top, mtop());
    end
  endtask

  // mode: 0 push then next, 1 both together, 2 next without push,
  //       3 no strobe at all, 4 push then no next
  task automatic do_issue(input logic [1:0] np_raw, input logic [1:0] nu_raw, input int mode,
                          input logic [31:0] o1, input logic [31:0] o2, input bit with_ext);
    int npc, nuc, c;
    bit ok_path;
    done_exp_t d;
    op_exp_t o;
    npc = (np_raw == 2'd3) ? 2 : int'(np_raw);
    nuc = (nu_raw == 2'd3) ? 2 : int'(nu_raw);
    ok_path = 1'b0;
    if (stk.size() < npc) d.err = 2'd1;
    else if (stk.size() - npc + nuc > DEPTH) d.err = 2'd2;
    else begin
      ok_path = 1'b1;
      o.in1 = (npc >= 1) ? stk[$] : 32'd0;
      o.in2 = (npc >= 2) ? stk[$-1] : 32'd0;
      op_q.push_back(o);
      repeat (npc) void'(stk.pop_back());
      if (mode == 0 || mode == 1 || mode == 4) begin
        if (nuc >= 1) stk.push_back(o1);
        if (nuc == 2) stk.push_back(o2);
      end
      d.err = (mode <= 1) ? 2'd0 : 2'd3;
    end
    d.cnt = stk.size();
    d.top = mtop();
    done_q.push_back(d);

    step();
    start = 1'b1; n_pop = np_raw; n_push = nu_raw;
    ext_push = with_ext; ext_data = $urandom;
    step();
    start = 1'b0; ext_push = 1'b0;
    if (!ok_path) begin
      wait_done(c);
      chk("err_path_latency", c, 1);
    end else begin
      @(negedge clk);
      chk("enable_latency", 32'(alu_enable), 1);
      alu_out1 = o1; alu_out2 = o2;
      case (mode)
        0: begin
          repeat ($urandom_range(1, 3)) step();
          alu_push_result = 1'b1;
          step();
          alu_push_result = 1'b0;
          repeat ($urandom_range(0, 3)) step();
          alu_next = 1'b1;
          step();
          alu_next = 1'b0;
          wait_done(c);
          chk("done_seen", 32'(c > 0), 1);
        end
        1, 2, 4: begin
          step();
          alu_push_result = (mode != 2);
          alu_next = (mode != 4);
          step();
          alu_push_result = 1'b0; alu_next = 1'b0;
          wait_done(c);
          chk("done_seen", 32'(c > 0), 1);
        end
        default: begin
          wait_done(c);
          chk("timeout_latency", c, TIMEOUT + 1);
        end
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    stk.delete();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // Reset lands while the sequencer sits in WAIT_NEXT with results already pushed.
  task automatic do_reset_mid();
    op_exp_t o;
    o.in1 = stk[$]; o.in2 = 32'd0;
    op_q.push_back(o);
    step();
    start = 1'b1; n_pop = 2'd1; n_push = 2'd1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("rst_mid_enable", 32'(alu_enable), 1);
    step();
    alu_out1 = 32'hDEAD_BEEF; alu_push_result = 1'b1;
    step();
    alu_push_result = 1'b0;
    step();
    #2 nrst = 1'b0;
    stk.delete();
    #1;
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_alu_in1", alu_in1, 0);
    chk("rst_mid_top", top, 0);
    #3 nrst = 1'b1;
    step();
    alu_next = 1'b1;
    step();
    alu_next = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_done", 32'(done), 0);
    end
    chk("post_rst_count", 32'(count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; start = 1'b0; ext_push = 1'b0; alu_push_result = 1'b0; alu_next = 1'b0;
    n_pop = 2'd0; n_push = 2'd0; ext_data = '0; alu_out1 = '0; alu_out2 = '0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_enable", 32'(alu_enable), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);
    chk("rst_top", top, 0);
    @(negedge clk);
    nrst = 1'b1;

    do_ext(32'd5);
    do_ext(32'd7);
    do_issue(2'd2, 2'd1, 0, 32'd12, 32'd0, 1'b0);
    do_issue(2'd2, 2'd1, 0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 15; i++) do_ext($urandom);
    do_issue(2'd1, 2'd2, 0, 32'd1, 32'd2, 1'b0);
    do_ext(32'h1234_5678);

    do_reset();
    do_ext(32'hFFFF_FFFF);
    do_ext(32'd1);
    do_issue(2'd2, 2'd2, 0, 32'd0, 32'd1, 1'b0);
    do_issue(2'd1, 2'd0, 0, 32'd0, 32'd0, 1'b0);
    do_issue(2'd3, 2'd0, 0, 32'd0, 32'd0, 1'b1);

    for (int i = 0; i < 3; i++) do_ext($urandom);
    do_issue(2'd2, 2'd1, 3, 32'd9, 32'd9, 1'b0);
    do_issue(2'd0, 2'd3, 4, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
    do_issue(2'd1, 2'd1, 2, 32'd3, 32'd4, 1'b0);
    do_issue(2'd0, 2'd1, 1, 32'h0BAD_F00D, 32'd0, 1'b0);

    do_reset_mid();

    for (int i = 0; i < 80; i++) begin
      int r, m;
      r = $urandom_range(0, 9);
      m = $urandom_range(0, 9);
      if (r < 4) do_ext($urandom);
      else do_issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    (m <= 5) ? 0 : m - 5, $urandom, $urandom, ($urandom_range(0, 7) == 0));
    end

    repeat (3) step();
    chk("pending_done_records", done_q.size(), 0);
    chk("pending_operand_records", op_q.size(), 0);
    chk("final_count", 32'(count), stk.size());
    chk("final_top", top, mtop());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
